// File: rtl/read_b_in_nbank_pkg.sv
// Shared helpers for the n-bank leaf-interface read side: width derivations
// used by the top level and the freespace tracker.
package read_b_in_nbank_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int bank_bits(input int num_banks);
      return clog2(num_banks);
   endfunction

   function automatic int bank_addr_bits(input int num_addr_bits, input int num_banks);
      return num_addr_bits - clog2(num_banks);
   endfunction

   function automatic int word_bits(input int payload_bits);
      return payload_bits + 1;
   endfunction

endpackage

// File: rtl/read_b_in_nbank_freespace_tracker.sv
// Consume accounting: returns one credit pulse per UPDATE_SIZE consumes and
// keeps a free-running consumed-word total for debug.
module read_b_in_nbank_freespace_tracker
   import read_b_in_nbank_pkg::*;
#(
   parameter int CNT_W       = 4,
   parameter int UPDATE_SIZE = 4,
   parameter int TOTAL_W     = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_consume,
   output logic               o_freespace_update,
   output logic [TOTAL_W-1:0] o_consumed_total
);

   logic [CNT_W-1:0]   r_cnt;
   logic               r_fsu;
   logic [TOTAL_W-1:0] r_total;
   logic               w_last;

   assign w_last = (r_cnt == CNT_W'(UPDATE_SIZE - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_fsu   <= 1'b0;
         r_total <= '0;
      end else begin
         // Pulse lands in the cycle after the consume that completes a block.
         r_fsu <= i_consume & w_last;
         if (i_consume) begin
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_total <= r_total + 1'b1;
         end
      end
   end

   assign o_freespace_update = r_fsu;
   assign o_consumed_total   = r_total;

endmodule

// File: rtl/read_b_in_nbank.sv
// Read side of the leaf-interface input buffer: presents NUM_BANKS BRAM banks
// round-robin to the user and invalidates each word as it is consumed.
module read_b_in_nbank
   import read_b_in_nbank_pkg::*;
#(
   parameter int NUM_BANKS             = 2,
   parameter int PAYLOAD_BITS          = 64,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64,
   parameter int CNT_BITS              = 32
)(
   input  logic                                                     clk,
   input  logic                                                     reset,
   input  logic                                                     ack_user2b_in,
   input  logic [NUM_BANKS*(PAYLOAD_BITS+1)-1:0]                    doutb,
   output logic [NUM_BANKS*(NUM_ADDR_BITS-clog2(NUM_BANKS))-1:0]    addrb,
   output logic [NUM_BANKS-1:0]                                     web,
   output logic [PAYLOAD_BITS-1:0]                                  dout_leaf_interface2user,
   output logic                                                     vld_bram_in2user,
   output logic                                                     freespace_update,
   output logic [CNT_BITS-1:0]                                      consumed_total
);

   localparam int BANK_BITS = bank_bits(NUM_BANKS);
   localparam int BA        = bank_addr_bits(NUM_ADDR_BITS, NUM_BANKS);
   localparam int WORD_BITS = word_bits(PAYLOAD_BITS);

   logic [WORD_BITS-1:0] w_bank_word [NUM_BANKS];
   logic [BA-1:0]        r_addr      [NUM_BANKS];
   logic [BANK_BITS-1:0] r_ptr;
   logic [WORD_BITS-1:0] w_cur;
   logic                 w_vld;
   logic                 w_consume;
   logic [NUM_BANKS-1:0] w_web;

   for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      assign w_bank_word[k]      = doutb[k*WORD_BITS +: WORD_BITS];
      assign addrb[k*BA +: BA]   = r_addr[k];
   end

   // Reset gates the valid bit, which in turn suppresses web and all state updates.
   assign w_cur     = w_bank_word[r_ptr];
   assign w_vld     = w_cur[WORD_BITS-1] & ~reset;
   assign w_consume = w_vld & ack_user2b_in;

   assign dout_leaf_interface2user = w_cur[PAYLOAD_BITS-1:0];
   assign vld_bram_in2user         = w_vld;

   always_comb begin
      w_web = '0;
      if (w_consume) w_web[r_ptr] = 1'b1;
   end

   assign web = w_web;

   // The same bank is revisited no sooner than two cycles later, so its
   // 1-cycle BRAM read has already caught up with the advanced address.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
         for (int k = 0; k < NUM_BANKS; k++) r_addr[k] <= '0;
      end else if (w_consume) begin
         r_ptr         <= r_ptr + 1'b1;
         r_addr[r_ptr] <= r_addr[r_ptr] + 1'b1;
      end
   end

   read_b_in_nbank_freespace_tracker #(
      .CNT_W       (BA + 1),
      .UPDATE_SIZE (FREESPACE_UPDATE_SIZE),
      .TOTAL_W     (CNT_BITS)
   ) u_tracker (
      .clk                (clk),
      .reset              (reset),
      .i_consume          (w_consume),
      .o_freespace_update (freespace_update),
      .o_consumed_total   (consumed_total)
   );

endmodule

// File: tb/tb_read_b_in_nbank.sv
// Bench for read_b_in_nbank: a 2-bank and a 4-bank instance, each fed by a
// behavioural 1-cycle-read BRAM model, with a payload scoreboard per instance.
module tb_read_b_in_nbank;

   localparam int PB  = 8;
   localparam int WB  = PB + 1;
   localparam int NB2 = 2;
   localparam int BA2 = 3;
   localparam int NB4 = 4;
   localparam int BA4 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst2, ack2, vld2, fsu2;
   logic [NB2*WB-1:0]  doutb2;
   logic [NB2*BA2-1:0] addrb2;
   logic [NB2-1:0]     web2;
   logic [PB-1:0]      dout2;
   logic [31:0]        tot2;

   logic               rst4, ack4, vld4, fsu4;
   logic [NB4*WB-1:0]  doutb4;
   logic [NB4*BA4-1:0] addrb4;
   logic [NB4-1:0]     web4;
   logic [PB-1:0]      dout4;
   logic [31:0]        tot4;

   logic          ld2_en, ld4_en;
   int            ld2_idx, ld4_idx;
   logic [WB-1:0] ld2_word, ld4_word;

   logic [WB-1:0] mem2 [16] = '{default: '0};
   logic [WB-1:0] mem4 [32] = '{default: '0};

   read_b_in_nbank #(.NUM_BANKS(2), .PAYLOAD_BITS(PB), .NUM_ADDR_BITS(4),
                     .FREESPACE_UPDATE_SIZE(4), .CNT_BITS(32)) dut2 (
      .clk(clk), .reset(rst2), .ack_user2b_in(ack2), .doutb(doutb2), .addrb(addrb2),
      .web(web2), .dout_leaf_interface2user(dout2), .vld_bram_in2user(vld2),
      .freespace_update(fsu2), .consumed_total(tot2));

   // 4-bank instance gets one extra address bit so each bank holds 8 words.
   read_b_in_nbank #(.NUM_BANKS(4), .PAYLOAD_BITS(PB), .NUM_ADDR_BITS(5),
                     .FREESPACE_UPDATE_SIZE(4), .CNT_BITS(32)) dut4 (
      .clk(clk), .reset(rst4), .ack_user2b_in(ack4), .doutb(doutb4), .addrb(addrb4),
      .web(web4), .dout_leaf_interface2user(dout4), .vld_bram_in2user(vld4),
      .freespace_update(fsu4), .consumed_total(tot4));

   always @(posedge clk) begin
      for (int k = 0; k < NB2; k++) begin
         doutb2[k*WB +: WB] <= mem2[k*8 + int'(addrb2[k*BA2 +: BA2])];
         if (web2[k]) mem2[k*8 + int'(addrb2[k*BA2 +: BA2])] <= '0;
      end
      if (ld2_en) mem2[ld2_idx] <= ld2_word;
   end

   always @(posedge clk) begin
      for (int k = 0; k < NB4; k++) begin
         doutb4[k*WB +: WB] <= mem4[k*8 + int'(addrb4[k*BA4 +: BA4])];
         if (web4[k]) mem4[k*8 + int'(addrb4[k*BA4 +: BA4])] <= '0;
      end
      if (ld4_en) mem4[ld4_idx] <= ld4_word;
   end

   int checks = 0;
   int errors = 0;
   logic [PB-1:0] q2[$];
   logic [PB-1:0] q4[$];

   typedef struct { logic [PB-1:0] dout; logic [3:0] web; } strm_t;
   typedef struct { logic [1:0] web; logic fsu; } cred_t;
   strm_t strm [16];
   cred_t cred [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Negedge sample point; every consume is scored against its queue.
   task automatic half();
      @(negedge clk);
      if (vld2 && ack2) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb2_unexpected: got %0h expected no consume", dout2);
         end else chk("sb2_dout", dout2, q2.pop_front());
      end
      if (vld4 && ack4) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb4_unexpected: got %0h expected no consume", dout4);
         end else chk("sb4_dout", dout4, q4.pop_front());
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      ld2_en = 1'b0;
      ld4_en = 1'b0;
   endtask

   task automatic ld2_set(input int w, input logic [PB-1:0] pl);
      ld2_en   = 1'b1;
      ld2_idx  = (w % 2) * 8 + (w / 2) % 8;
      ld2_word = {1'b1, pl};
      q2.push_back(pl);
   endtask

   task automatic ld4_set(input int w, input logic [PB-1:0] pl);
      ld4_en   = 1'b1;
      ld4_idx  = (w % 4) * 8 + (w / 4) % 8;
      ld4_word = {1'b1, pl};
      q4.push_back(pl);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int pulses;
      for (int w = 0; w < 16; w++) begin
         strm[w].dout = PB'(w);
         strm[w].web  = 4'(1 << (w % 4));
      end
      for (int i = 0; i < 9; i++) begin
         cred[i].web = (i < 8) ? 2'(1 << (i % 2)) : 2'b00;
         cred[i].fsu = (i == 4) || (i == 8);
      end

      rst2 = 1'b1; rst4 = 1'b1; ack2 = 1'b1; ack4 = 1'b1;
      ld2_en = 1'b0; ld4_en = 1'b0; ld2_idx = 0; ld4_idx = 0;
      ld2_word = '0; ld4_word = '0;
      adv();
      for (int w = 0; w < 16; w++) begin ld4_set(w, PB'(w)); adv(); end
      for (int w = 0; w < 8; w++) begin ld2_set(w, 8'hA0 + PB'(w)); adv(); end

      // Reset held with valid words present and ack high
      for (int c = 0; c < 3; c++) begin
         half();
         chk("rst_vld", 32'(vld2), 0);
         chk("rst_web", 32'(web2), 0);
         chk("rst_addrb", 32'(addrb2), 0);
         chk("rst_fsu", 32'(fsu2), 0);
         chk("rst_tot", tot2, 0);
         chk("rst_vld4", 32'(vld4), 0);
         chk("rst_web4", 32'(web4), 0);
         adv();
      end

      // 4-bank streaming, one word per cycle
      rst4 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         half();
         chk("strm_vld", 32'(vld4), 1);
         chk("strm_dout", 32'(dout4), 32'(strm[i].dout));
         chk("strm_web", 32'(web4), 32'(strm[i].web));
         adv();
      end
      ack4 = 1'b0;
      half();
      chk("strm_addrb", 32'(addrb4), 32'h924);
      chk("strm_tot", tot4, 16);
      chk("strm_idle_web", 32'(web4), 0);
      adv();

      // Credit pulse over 8 back-to-back consumes
      rst2 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         half();
         chk("cred_web", 32'(web2), 32'(cred[i].web));
         chk("cred_fsu", 32'(fsu2), 32'(cred[i].fsu));
         if (i == 8) begin
            chk("cred_tot", tot2, 8);
            chk("cred_addrb", 32'(addrb2), 32'h24);
         end
         adv();
         if (i == 7) ack2 = 1'b0;
      end

      // Empty word with ack high; it turns valid for cycle 5
      ack2 = 1'b1;
      for (int s = 1; s <= 5; s++) begin
         half();
         if (s < 5) begin
            chk("stall_web", 32'(web2), 0);
            chk("stall_vld", 32'(vld2), 0);
            chk("stall_addrb", 32'(addrb2), 32'h24);
         end else begin
            chk("stall_web_go", 32'(web2), 1);
            chk("stall_vld_go", 32'(vld2), 1);
         end
         if (s == 3) ld2_set(8, 8'hB8);
         adv();
      end
      ack2 = 1'b0;
      half();
      chk("stall_addrb_after", 32'(addrb2), 32'h25);
      chk("stall_tot", tot2, 9);
      adv();

      // Wrap: 17 consumes from a clean start, refilling bank0 addr0 in flight
      rst2 = 1'b1; half(); adv(); rst2 = 1'b0;
      for (int w = 0; w < 16; w++) begin ld2_set(w, 8'hC0 + PB'(w)); adv(); end
      ack2 = 1'b1;
      pulses = 0;
      for (int i = 0; i < 18; i++) begin
         half();
         chk("wrap_web", 32'(web2), (i < 17) ? 32'(1 << (i % 2)) : 0);
         if (fsu2) pulses++;
         if (i == 14) chk("wrap_a0_7", 32'(addrb2[2:0]), 7);
         if (i == 15) chk("wrap_a0_0", 32'(addrb2[2:0]), 0);
         if (i == 17) begin
            chk("wrap_addrb", 32'(addrb2), 32'h01);
            chk("wrap_tot", tot2, 17);
         end
         if (i == 1) ld2_set(16, 8'hD0);
         adv();
         if (i == 16) ack2 = 1'b0;
      end
      chk("wrap_pulses", pulses, 4);

      // Reset lands on the 3rd consume
      rst2 = 1'b1; half(); adv(); rst2 = 1'b0;
      for (int w = 0; w < 6; w++) begin ld2_set(w, 8'h60 + PB'(w)); adv(); end
      ack2 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         half();
         chk("mrst_web", 32'(web2), 32'(1 << i));
         adv();
      end
      rst2 = 1'b1;
      half();
      chk("mrst_web_sup", 32'(web2), 0);
      chk("mrst_vld_sup", 32'(vld2), 0);
      adv();
      rst2 = 1'b0; ack2 = 1'b0;
      q2.delete();
      half();
      chk("mrst_addrb", 32'(addrb2), 0);
      chk("mrst_fsu", 32'(fsu2), 0);
      chk("mrst_tot", tot2, 0);
      adv();
      for (int w = 0; w < 5; w++) begin ld2_set(w, 8'h70 + PB'(w)); adv(); end
      ack2 = 1'b1;
      for (int j = 0; j < 6; j++) begin
         half();
         chk("mrst_fsu_new", 32'(fsu2), (j == 4) ? 1 : 0);
         chk("mrst_web_new", 32'(web2), (j < 5) ? 32'(1 << (j % 2)) : 0);
         if (j == 5) chk("mrst_tot_new", tot2, 5);
         adv();
         if (j == 4) ack2 = 1'b0;
      end

      chk("sb2_drained", q2.size(), 0);
      chk("sb4_drained", q4.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
